// File: rtl/branch_cond_unit_pkg.sv
// Shared encodings for the branch condition unit: condition codes, FSM states
// and bit positions inside the {zf,cf,of,sf} flag vector.
package branch_cond_unit_pkg;

    typedef enum logic [2:0] {
        COND_EQ     = 3'b000,
        COND_NE     = 3'b001,
        COND_LT     = 3'b010,
        COND_GE     = 3'b011,
        COND_LTU    = 3'b100,
        COND_GEU    = 3'b101,
        COND_ALWAYS = 3'b110,
        COND_NEVER  = 3'b111
    } br_cond_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } bcu_state_e;

    localparam int FLAG_ZF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_SF = 0;

    localparam logic [1:0] PENDING_MAX = 2'd3;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Combinational branch condition evaluator: condition code plus flag vector
// produce the resolved branch direction.
module branch_cond_unit_cond_eval
    import branch_cond_unit_pkg::*;
(
    input  logic [2:0] br_cond,
    input  logic [3:0] flags,
    output logic       taken
);

    br_cond_e cond_s;
    logic     zf_s;
    logic     cf_s;
    logic     of_s;
    logic     sf_s;

    assign cond_s = br_cond_e'(br_cond);
    assign zf_s   = flags[FLAG_ZF];
    assign cf_s   = flags[FLAG_CF];
    assign of_s   = flags[FLAG_OF];
    assign sf_s   = flags[FLAG_SF];

    // Decode the condition; cf is the borrow of a-b, so LTU is plain cf.
    always_comb begin
        taken = 1'b0;
        case (cond_s)
            COND_EQ:     taken = zf_s;
            COND_NE:     taken = ~zf_s;
            COND_LT:     taken = sf_s ^ of_s;
            COND_GE:     taken = ~(sf_s ^ of_s);
            COND_LTU:    taken = cf_s;
            COND_GEU:    taken = ~cf_s;
            COND_ALWAYS: taken = 1'b1;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds a branch request until all outstanding flag
// writes have landed, then resolves it against the flag register.
module branch_cond_unit
    import branch_cond_unit_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             zf,
    input  logic             cf,
    input  logic             of,
    input  logic             sf,
    input  logic             flag_we,
    input  logic             flag_issue,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_cond,
    input  logic [WIDTH-1:0] br_pc,
    input  logic [WIDTH-1:0] br_target,
    input  logic             flush,
    output logic             redirect_valid,
    output logic             taken,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [3:0]       flags_q,
    output logic [1:0]       pending
);

    bcu_state_e       state_r;
    bcu_state_e       state_s;
    logic [1:0]       pending_r;
    logic [1:0]       pending_s;
    logic [3:0]       flags_r;
    logic [2:0]       cond_r;
    logic [WIDTH-1:0] target_r;
    logic [WIDTH-1:0] pc4_r;
    logic             redirect_valid_r;
    logic             taken_r;
    logic [WIDTH-1:0] redirect_pc_r;
    logic             accept_s;
    logic             eval_s;
    logic             eval_taken_s;

    branch_cond_unit_cond_eval cond_eval_u (
        .br_cond (cond_r),
        .flags   (flags_r),
        .taken   (eval_taken_s)
    );

    // Next-state logic; flush overrides acceptance and resolution.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        eval_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (br_valid && !flush) begin
                    accept_s = 1'b1;
                    state_s  = ST_WAIT;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_s = ST_IDLE;
                end else if (pending_r == 2'd0) begin
                    eval_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Outstanding flag-write counter, saturating at both ends.
    always_comb begin
        pending_s = pending_r;
        if (flush) begin
            pending_s = 2'd0;
        end else if (flag_issue && !flag_we && (pending_r != PENDING_MAX)) begin
            pending_s = pending_r + 2'd1;
        end else if (flag_we && !flag_issue && (pending_r != 2'd0)) begin
            pending_s = pending_r - 2'd1;
        end else begin
            pending_s = pending_r;
        end
    end

    // Flag register loads independently of the FSM and of flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= 4'b0000;
        end else if (flag_we) begin
            flags_r <= {zf, cf, of, sf};
        end else begin
            flags_r <= flags_r;
        end
    end

    // FSM state, counter, latched request and registered redirect outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            pending_r        <= 2'd0;
            cond_r           <= 3'b000;
            target_r         <= {WIDTH{1'b0}};
            pc4_r            <= {WIDTH{1'b0}};
            redirect_valid_r <= 1'b0;
            taken_r          <= 1'b0;
            redirect_pc_r    <= {WIDTH{1'b0}};
        end else begin
            state_r          <= state_s;
            pending_r        <= pending_s;
            redirect_valid_r <= eval_s;
            if (accept_s) begin
                cond_r   <= br_cond;
                target_r <= br_target;
                pc4_r    <= br_pc + {{(WIDTH-3){1'b0}}, 3'd4};
            end
            if (eval_s) begin
                taken_r       <= eval_taken_s;
                redirect_pc_r <= eval_taken_s ? target_r : pc4_r;
            end
        end
    end

    assign br_ready       = (state_r == ST_IDLE);
    assign redirect_valid = redirect_valid_r;
    assign taken          = taken_r;
    assign redirect_pc    = redirect_pc_r;
    assign flags_q        = flags_r;
    assign pending        = pending_r;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed self-checking bench for branch_cond_unit with hand-computed
// expected values.
module tb_branch_cond_unit;

    logic        clk;
    logic        rst;
    logic        zf, cf, of, sf;
    logic        flag_we;
    logic        flag_issue;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic [31:0] br_pc;
    logic [31:0] br_target;
    logic        flush;
    logic        redirect_valid;
    logic        taken;
    logic [31:0] redirect_pc;
    logic [3:0]  flags_q;
    logic [1:0]  pending;

    int total_cnt;
    int bad_cnt;

    branch_cond_unit #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .zf             (zf),
        .cf             (cf),
        .of             (of),
        .sf             (sf),
        .flag_we        (flag_we),
        .flag_issue     (flag_issue),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_cond        (br_cond),
        .br_pc          (br_pc),
        .br_target      (br_target),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .taken          (taken),
        .redirect_pc    (redirect_pc),
        .flags_q        (flags_q),
        .pending        (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        {zf, cf, of, sf} = f;
        flag_we = 1'b1;
        tick();
        flag_we = 1'b0;
    endtask

    task automatic req(input logic [2:0] c, input logic [31:0] pc, input logic [31:0] tgt);
        br_valid  = 1'b1;
        br_cond   = c;
        br_pc     = pc;
        br_target = tgt;
    endtask

    logic [2:0]  tab_cond [8];
    logic [3:0]  tab_flags[8];
    logic        tab_exp  [8];

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst = 1'b1;
        {zf, cf, of, sf} = 4'b0000;
        flag_we = 1'b0; flag_issue = 1'b0; br_valid = 1'b0; flush = 1'b0;
        br_cond = 3'b000; br_pc = 32'h0; br_target = 32'h0;

        // {cond, flags {zf,cf,of,sf}, expected taken}
        tab_cond[0] = 3'b001; tab_flags[0] = 4'b1000; tab_exp[0] = 1'b0;
        tab_cond[1] = 3'b011; tab_flags[1] = 4'b0011; tab_exp[1] = 1'b1;
        tab_cond[2] = 3'b010; tab_flags[2] = 4'b0011; tab_exp[2] = 1'b0;
        tab_cond[3] = 3'b100; tab_flags[3] = 4'b0100; tab_exp[3] = 1'b1;
        tab_cond[4] = 3'b101; tab_flags[4] = 4'b0100; tab_exp[4] = 1'b0;
        tab_cond[5] = 3'b110; tab_flags[5] = 4'b0000; tab_exp[5] = 1'b1;
        tab_cond[6] = 3'b111; tab_flags[6] = 4'b1111; tab_exp[6] = 1'b0;
        tab_cond[7] = 3'b000; tab_flags[7] = 4'b0000; tab_exp[7] = 1'b0;

        #2;
        chk("rst_rv", 64'(redirect_valid), 64'd0);
        chk("rst_pc", 64'(redirect_pc), 64'd0);
        #10 rst = 1'b0;
        tick();
        chk("rst_ready", 64'(br_ready), 64'd1);
        chk("rst_pend", 64'(pending), 64'd0);
        chk("rst_flags", 64'(flags_q), 64'd0);
        chk("rst_taken", 64'(taken), 64'd0);

        // Basic EQ taken, minimum latency
        set_flags(4'b1000);
        chk("eq_flags", 64'(flags_q), 64'h8);
        chk("pend_floor", 64'(pending), 64'd0);
        req(3'b000, 32'h40, 32'h100);
        tick();
        br_valid = 1'b0;
        chk("eq_n1_ready", 64'(br_ready), 64'd0);
        chk("eq_n1_rv", 64'(redirect_valid), 64'd0);
        tick();
        chk("eq_rv", 64'(redirect_valid), 64'd1);
        chk("eq_taken", 64'(taken), 64'd1);
        chk("eq_pc", 64'(redirect_pc), 64'h100);
        tick();
        chk("eq_pulse", 64'(redirect_valid), 64'd0);
        chk("eq_hold_pc", 64'(redirect_pc), 64'h100);
        chk("eq_hold_tk", 64'(taken), 64'd1);

        // LT waits for an outstanding flag write
        flag_issue = 1'b1;
        tick();
        flag_issue = 1'b0;
        chk("lt_pend1", 64'(pending), 64'd1);
        req(3'b010, 32'h200, 32'h300);
        tick();
        br_valid = 1'b0;
        chk("lt_n2_rv", 64'(redirect_valid), 64'd0);
        tick();
        {zf, cf, of, sf} = 4'b0001;
        flag_we = 1'b1;
        chk("lt_n3_rv", 64'(redirect_valid), 64'd0);
        tick();
        flag_we = 1'b0;
        chk("lt_n4_rv", 64'(redirect_valid), 64'd0);
        chk("lt_n4_pend", 64'(pending), 64'd0);
        chk("lt_n4_flags", 64'(flags_q), 64'h1);
        tick();
        chk("lt_rv", 64'(redirect_valid), 64'd1);
        chk("lt_taken", 64'(taken), 64'd1);
        chk("lt_pc", 64'(redirect_pc), 64'h300);

        // LTU not taken, pc+4 wraps; back-to-back GEU in the redirect cycle
        set_flags(4'b0000);
        req(3'b100, 32'hFFFF_FFFC, 32'h500);
        tick();
        br_valid = 1'b0;
        tick();
        chk("ltu_rv", 64'(redirect_valid), 64'd1);
        chk("ltu_taken", 64'(taken), 64'd0);
        chk("ltu_wrap", 64'(redirect_pc), 64'h0);
        chk("b2b_ready", 64'(br_ready), 64'd1);
        req(3'b101, 32'h10, 32'h800);
        tick();
        br_valid = 1'b0;
        tick();
        chk("b2b_rv", 64'(redirect_valid), 64'd1);
        chk("b2b_taken", 64'(taken), 64'd1);
        chk("b2b_pc", 64'(redirect_pc), 64'h800);

        // Condition table
        for (int i = 0; i < 8; i++) begin
            set_flags(tab_flags[i]);
            req(tab_cond[i], 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16));
            tick();
            br_valid = 1'b0;
            tick();
            chk($sformatf("tab%0d_rv", i), 64'(redirect_valid), 64'd1);
            chk($sformatf("tab%0d_tk", i), 64'(taken), 64'(tab_exp[i]));
            chk($sformatf("tab%0d_pc", i), 64'(redirect_pc),
                64'(tab_exp[i] ? 32'h2000 + 32'(i * 16) : 32'h1004 + 32'(i * 16)));
        end

        // Saturation of pending
        flag_issue = 1'b1;
        repeat (4) tick();
        chk("pend_sat", 64'(pending), 64'd3);
        flag_we = 1'b1;
        tick();
        chk("pend_both", 64'(pending), 64'd3);
        flag_issue = 1'b0;
        tick();
        flag_we = 1'b0;
        chk("pend_dec", 64'(pending), 64'd2);

        // Flush while waiting with pending=2
        req(3'b110, 32'h60, 32'h900);
        tick();
        br_valid = 1'b0;
        tick();
        chk("fl_wait_ready", 64'(br_ready), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_ready", 64'(br_ready), 64'd1);
        chk("fl_pend", 64'(pending), 64'd0);
        chk("fl_rv", 64'(redirect_valid), 64'd0);
        tick();
        chk("fl_rv2", 64'(redirect_valid), 64'd0);
        tick();
        chk("fl_rv3", 64'(redirect_valid), 64'd0);

        // Request alongside flush is dropped
        req(3'b110, 32'h70, 32'hA00);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        br_valid = 1'b0;
        chk("flreq_ready", 64'(br_ready), 64'd1);
        tick();
        chk("flreq_rv", 64'(redirect_valid), 64'd0);

        // Flush in the resolving cycle suppresses the pulse
        req(3'b110, 32'h80, 32'hB00);
        tick();
        br_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flev_rv", 64'(redirect_valid), 64'd0);
        tick();
        chk("flev_rv2", 64'(redirect_valid), 64'd0);
        chk("flev_pc", 64'(redirect_pc), 64'h1074);

        // Asynchronous reset mid-WAIT
        flag_issue = 1'b1;
        tick();
        flag_issue = 1'b0;
        req(3'b110, 32'h90, 32'hC00);
        tick();
        br_valid = 1'b0;
        tick();
        chk("ar_wait", 64'(br_ready), 64'd0);
        #3 rst = 1'b1;
        #1;
        chk("ar_rv", 64'(redirect_valid), 64'd0);
        chk("ar_pc", 64'(redirect_pc), 64'd0);
        chk("ar_flags", 64'(flags_q), 64'd0);
        chk("ar_pend", 64'(pending), 64'd0);
        chk("ar_ready", 64'(br_ready), 64'd1);
        #2 rst = 1'b0;
        tick();
        chk("ar_rel_ready", 64'(br_ready), 64'd1);
        chk("ar_rel_rv", 64'(redirect_valid), 64'd0);
        tick();
        chk("ar_rel_rv2", 64'(redirect_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
